// File: rtl/instr_split_pkg.sv
// Shared decode-front widths, serializer states and PC step for instr_split.
package instr_split_pkg;

   localparam int WFID_W  = 6;
   localparam int WORD_W  = 32;
   localparam int PC_W    = 32;
   localparam int INSTR_W = 2 * WORD_W;

   localparam logic [PC_W-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } state_t;

endpackage

// File: rtl/instr_split.sv
// Splits one fetched instruction into one or two 32-bit words; first word 1 cycle after accept.
// Registered outputs freeze under out_stall; in_ready drops while a long second half is pending.
module instr_split
   import instr_split_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WFID_W-1:0]    in_wfid,
   input  logic [INSTR_W-1:0]   in_instr,
   input  logic [PC_W-1:0]      in_pc,
   input  logic                 in_long,
   input  logic                 flush_valid,
   input  logic [WFID_W-1:0]    flush_wfid,
   input  logic                 out_stall,
   output logic                 out_valid,
   output logic [WFID_W-1:0]    out_wfid,
   output logic [WORD_W-1:0]    out_instr,
   output logic [PC_W-1:0]      out_pc,
   output logic                 out_long
);

   state_t              state;
   state_t              state_nxt;

   logic [WFID_W-1:0]   held_wfid;
   logic [WORD_W-1:0]   held_hi;
   logic [PC_W-1:0]     held_pc;
   logic                held_long;

   logic                accept;
   logic                take;
   logic                in_flush_hit;
   logic                held_flush_hit;
   logic                load_first;
   logic                load_second;

   always_comb begin
      in_ready = 1'b0;
      case (state)
         EMPTY:   in_ready = 1'b1;
         FIRST:   in_ready = ~held_long & ~out_stall;
         SECOND:  in_ready = ~out_stall;
         default: in_ready = 1'b0;
      endcase
   end

   // A flushed wavefront's accept is still handshaken so fetch sees it consumed.
   assign accept         = in_valid & in_ready;
   assign in_flush_hit   = flush_valid & (flush_wfid == in_wfid);
   assign take           = accept & ~in_flush_hit;
   assign held_flush_hit = flush_valid & (flush_wfid == held_wfid);

   always_comb begin
      state_nxt   = state;
      load_first  = 1'b0;
      load_second = 1'b0;
      case (state)
         EMPTY: begin
            if (take) begin
               state_nxt  = FIRST;
               load_first = 1'b1;
            end
         end
         FIRST: begin
            if (held_flush_hit) begin
               state_nxt  = take ? FIRST : EMPTY;
               load_first = take;
            end else if (!out_stall) begin
               if (held_long) begin
                  state_nxt   = SECOND;
                  load_second = 1'b1;
               end else begin
                  state_nxt  = take ? FIRST : EMPTY;
                  load_first = take;
               end
            end
         end
         // Flush is ignored here so collate never sees an unpaired first half.
         SECOND: begin
            if (!out_stall) begin
               state_nxt  = take ? FIRST : EMPTY;
               load_first = take;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt != EMPTY);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         held_wfid <= '0;
         held_hi   <= '0;
         held_pc   <= '0;
         held_long <= 1'b0;
      end else if (load_first) begin
         held_wfid <= in_wfid;
         held_hi   <= in_instr[INSTR_W-1:WORD_W];
         held_pc   <= in_pc;
         held_long <= in_long;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_wfid  <= '0;
         out_instr <= '0;
         out_pc    <= '0;
         out_long  <= 1'b0;
      end else if (load_first) begin
         out_wfid  <= in_wfid;
         out_instr <= in_instr[WORD_W-1:0];
         out_pc    <= in_pc;
         out_long  <= in_long;
      end else if (load_second) begin
         out_wfid  <= held_wfid;
         out_instr <= held_hi;
         out_pc    <= held_pc + PC_STEP;
         out_long  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_split.sv
// Directed bench for instr_split with hand-computed expected words.
module tb_instr_split;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [5:0]   in_wfid;
   logic [63:0]  in_instr;
   logic [31:0]  in_pc;
   logic         in_long;
   logic         flush_valid;
   logic [5:0]   flush_wfid;
   logic         out_stall;
   logic         out_valid;
   logic [5:0]   out_wfid;
   logic [31:0]  out_instr;
   logic [31:0]  out_pc;
   logic         out_long;

   int tests_run = 0;
   int tests_failed = 0;

   instr_split dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_wfid     (in_wfid),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_long     (in_long),
      .flush_valid (flush_valid),
      .flush_wfid  (flush_wfid),
      .out_stall   (out_stall),
      .out_valid   (out_valid),
      .out_wfid    (out_wfid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_long    (out_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [5:0] wf, input logic [31:0] ins,
                           input logic [31:0] pc, input logic lng);
      chk({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, ".wfid"},  {58'd0, out_wfid},  {58'd0, wf});
      chk({tag, ".instr"}, {32'd0, out_instr}, {32'd0, ins});
      chk({tag, ".pc"},    {32'd0, out_pc},    {32'd0, pc});
      chk({tag, ".long"},  {63'd0, out_long},  {63'd0, lng});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [5:0] wf, input logic [63:0] ins, input logic [31:0] pc,
                        input logic lng);
      in_valid = 1'b1;
      in_wfid  = wf;
      in_instr = ins;
      in_pc    = pc;
      in_long  = lng;
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; in_wfid = '0; in_instr = '0; in_pc = '0; in_long = 1'b0;
      flush_valid = 1'b0; flush_wfid = '0; out_stall = 1'b0;
      #1;
      chk("rst.valid", {63'd0, out_valid}, 64'd0);
      chk("rst.ready", {63'd0, in_ready}, 64'd1);
      chk("rst.wfid",  {58'd0, out_wfid}, 64'd0);
      chk("rst.instr", {32'd0, out_instr}, 64'd0);
      chk("rst.pc",    {32'd0, out_pc}, 64'd0);
      chk("rst.long",  {63'd0, out_long}, 64'd0);
      step();
      rst = 1'b1;
      step();

      // short stream, 1 word per cycle
      offer(6'd3, 64'h0000_0000_0000_000A, 32'h100, 1'b0);
      #1 chk("short0.ready", {63'd0, in_ready}, 64'd1);
      step();
      chk_word("short0", 6'd3, 32'hA, 32'h100, 1'b0);
      offer(6'd3, 64'h0000_0000_0000_000B, 32'h104, 1'b0);
      #1 chk("short1.ready", {63'd0, in_ready}, 64'd1);
      step();
      chk_word("short1", 6'd3, 32'hB, 32'h104, 1'b0);
      offer(6'd3, 64'h0000_0000_0000_000C, 32'h108, 1'b0);
      #1 chk("short2.ready", {63'd0, in_ready}, 64'd1);
      step();
      chk_word("short2", 6'd3, 32'hC, 32'h108, 1'b0);
      in_valid = 1'b0;
      step();
      chk("short.drain", {63'd0, out_valid}, 64'd0);

      // long instruction
      offer(6'd5, 64'h1111_2222_3333_4444, 32'h200, 1'b1);
      step();
      in_valid = 1'b0;
      chk_word("long.w0", 6'd5, 32'h3333_4444, 32'h200, 1'b1);
      #1 chk("long.ready_n1", {63'd0, in_ready}, 64'd0);
      step();
      chk_word("long.w1", 6'd5, 32'h1111_2222, 32'h204, 1'b0);
      step();
      chk("long.drain", {63'd0, out_valid}, 64'd0);

      // stall during FIRST of a long instruction
      offer(6'd2, 64'hAAAA_BBBB_CCCC_DDDD, 32'h300, 1'b1);
      step();
      in_valid = 1'b0;
      out_stall = 1'b1;
      chk_word("stall.c0", 6'd2, 32'hCCCC_DDDD, 32'h300, 1'b1);
      step();
      chk_word("stall.c1", 6'd2, 32'hCCCC_DDDD, 32'h300, 1'b1);
      step();
      chk_word("stall.c2", 6'd2, 32'hCCCC_DDDD, 32'h300, 1'b1);
      out_stall = 1'b0;
      step();
      chk_word("stall.w1", 6'd2, 32'hAAAA_BBBB, 32'h304, 1'b0);
      step();
      chk("stall.drain", {63'd0, out_valid}, 64'd0);

      // flush in FIRST: non-matching first, then matching
      offer(6'd7, 64'h0000_0000_0000_0077, 32'h400, 1'b0);
      step();
      in_valid = 1'b0;
      out_stall = 1'b1;
      chk_word("fl1.held", 6'd7, 32'h77, 32'h400, 1'b0);
      #1 chk("fl1.ready", {63'd0, in_ready}, 64'd0);
      flush_valid = 1'b1;
      flush_wfid = 6'd8;
      step();
      chk_word("fl1.other", 6'd7, 32'h77, 32'h400, 1'b0);
      flush_wfid = 6'd7;
      step();
      chk("fl1.dropped", {63'd0, out_valid}, 64'd0);
      flush_valid = 1'b0;
      out_stall = 1'b0;
      step();
      chk("fl1.noword", {63'd0, out_valid}, 64'd0);

      // flush in SECOND is ignored
      offer(6'd5, 64'h5555_6666_7777_8888, 32'h500, 1'b1);
      step();
      in_valid = 1'b0;
      chk_word("fl2.w0", 6'd5, 32'h7777_8888, 32'h500, 1'b1);
      step();
      out_stall = 1'b1;
      flush_valid = 1'b1;
      flush_wfid = 6'd5;
      chk_word("fl2.w1a", 6'd5, 32'h5555_6666, 32'h504, 1'b0);
      step();
      flush_valid = 1'b0;
      out_stall = 1'b0;
      chk_word("fl2.w1b", 6'd5, 32'h5555_6666, 32'h504, 1'b0);
      step();
      chk("fl2.drain", {63'd0, out_valid}, 64'd0);

      // flush and accept of the same wavefront in one cycle
      offer(6'd9, 64'h0000_0000_0000_0099, 32'h580, 1'b0);
      flush_valid = 1'b1;
      flush_wfid = 6'd9;
      #1 chk("flacc.ready", {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      flush_valid = 1'b0;
      chk("flacc.dropped", {63'd0, out_valid}, 64'd0);

      // async reset while in SECOND
      offer(6'd4, 64'hDEAD_BEEF_0404_0404, 32'h600, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      chk_word("ar.w1", 6'd4, 32'hDEAD_BEEF, 32'h604, 1'b0);
      #2 rst = 1'b0;
      #1 chk("ar.valid", {63'd0, out_valid}, 64'd0);
      chk("ar.ready", {63'd0, in_ready}, 64'd1);
      step();
      rst = 1'b1;
      chk("ar.hold", {63'd0, out_valid}, 64'd0);
      offer(6'd1, 64'h0000_0000_0000_0070, 32'h700, 1'b0);
      #1 chk("ar.ready2", {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      chk_word("ar.next", 6'd1, 32'h70, 32'h700, 1'b0);
      step();
      chk("ar.drain", {63'd0, out_valid}, 64'd0);

      // PC wrap on the second half
      offer(6'd6, 64'h0BAD_F00D_1234_5678, 32'hFFFF_FFFC, 1'b1);
      step();
      in_valid = 1'b0;
      chk_word("wrap.w0", 6'd6, 32'h1234_5678, 32'hFFFF_FFFC, 1'b1);
      step();
      chk_word("wrap.w1", 6'd6, 32'h0BAD_F00D, 32'h0000_0000, 1'b0);
      step();
      chk("wrap.drain", {63'd0, out_valid}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/instr_split.md
# instr_split

Decode-front serializer: accepts one fetched instruction per handshake, up to 64 bits wide, tagged with wavefront id, PC and a long flag. It emits it as one or two 32-bit words on the word-per-cycle interface consumed by the collate stage. The first half of a 64-bit instruction carries the long flag and the instruction PC; the second half follows with the flag clear, so the collate stage can pair them per wavefront. The block sits between the fetch/instruction buffer and the collate stage. It owns the backpressure and flush handling for that link.

## Interface
- No parameters; wavefront id 6 bits (40 wavefronts), word 32 bits, PC 32 bits.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  block accepts the instruction this cycle
- in_wfid  in  6  wavefront id
- in_instr  in  64  instruction; [31:0] first word, [63:32] second word (ignored when short)
- in_pc  in  32  instruction PC
- in_long  in  1  instruction is 64-bit
- flush_valid  in  1  discard un-emitted work for flush_wfid
- flush_wfid  in  6  wavefront to flush
- out_stall  in  1  downstream cannot take a word this cycle
- out_valid  out  1  word valid
- out_wfid  out  6  wavefront id of word
- out_instr  out  32  instruction word
- out_pc  out  32  PC of word
- out_long  out  1  1 = first half of 64-bit instruction

## Operation
- State machine: EMPTY, FIRST (word 0 presented), SECOND (word 1 presented).
- Holding register: wfid, 64-bit instr, pc, long.
- Accept (in_valid & in_ready):
  - capture all fields into the holding register;
  - next state FIRST.
- in_ready = (state==EMPTY) | (state==FIRST & ~held_long & ~out_stall) | (state==SECOND & ~out_stall).
- Back-to-back short instructions therefore sustain 1 word/cycle.
- FIRST:
  - out_instr = held[31:0], out_pc = held_pc, out_long = held_long.
  - If ~out_stall:
    - held_long → SECOND;
    - otherwise → FIRST if a new accept happens this cycle, else EMPTY.
- SECOND:
  - out_instr = held[63:32], out_pc = held_pc + 4 (mod 2^32, wraps), out_long = 0.
  - If ~out_stall → FIRST on a new accept, else EMPTY.
- out_valid = (state != EMPTY). All out_* are registered. They hold stable while out_stall=1.
- Flush (flush_valid & flush_wfid == held_wfid):
  - FIRST: entry dropped, → EMPTY; out_valid falls next cycle.
  - SECOND: ignored. The second half of an already-emitted first half is always delivered, so the collate stage never keeps a dangling long flag.
  - Flush of a non-matching wfid: no effect.
- Flush and accept in the same cycle: the accept of a flushed wfid is also dropped, and in_ready still reads 1 (the fetch side considers it consumed).
- Accept has priority over nothing else; flush applies only to the held entry and to the same-cycle accept.

## Timing
- Reset values:
  - state = EMPTY, out_valid = 0, in_ready = 1;
  - out_wfid, out_instr, out_pc, out_long = 0.
- Latency: accept in cycle N → first word valid in cycle N+1.
- A long instruction's second word appears in N+2 (absent stall).
- Throughput: short 1/cycle; long 2 cycles/instruction; each stall cycle adds one.
- A word is transferred in any cycle with out_valid & ~out_stall.
- Reset asserted mid-instruction (including in SECOND) clears state immediately. Nothing further is emitted.

## Structure
- Shared decode package:
  - WFID_W = 6, WORD_W = 32, PC_W = 32;
  - state enum {EMPTY, FIRST, SECOND};
  - PC_STEP = 4.
- Single module. No sub-module needed; the holding register is inline flops with async active-low reset.

## Test plan
- Short stream, no stall:
  - stimulus: wf 3, pc 0x100/0x104/0x108, instr lows 0xA/0xB/0xC;
  - required: words in N+1..N+3, out_long=0, in_ready constantly 1.
- Long instruction:
  - stimulus: wf 5, pc 0x200, instr 0x1111_2222_3333_4444;
  - required: word 0x33334444 pc 0x200 long=1 at N+1; word 0x11112222 pc 0x204 long=0 at N+2; in_ready=0 at N+1.
- Stall: out_stall=1 for 3 cycles during FIRST of a long instruction → outputs frozen for 3 cycles, then the sequence completes unchanged.
- Flush in FIRST:
  - stimulus: hold wf 7 stalled, flush_wfid=7;
  - required: out_valid=0 next cycle, no word for wf 7.
  - A flush of wf 8 on the same setup changes nothing.
- Flush in SECOND: flush wf 5 while its second half is stalled → second half still delivered after the stall releases.
- Async reset asserted in SECOND → out_valid=0 immediately, in_ready=1 after release, next accept behaves normally.
- PC wrap: long instruction at pc 0xFFFF_FFFC → second word pc 0x0000_0000.
